// File: rtl/ram_sp_param.sv
// Parametrised single-port synchronous RAM with byte enables, read-valid strobe and a post-reset
// clear sweep. Define RAM_PARITY_EN to keep one even-parity bit per byte and flag read mismatches.
module ram_sp_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in,
  input  logic              par_flip,
  output logic [DATA_W-1:0] out,
  output logic              rd_valid,
  output logic              busy,
  output logic              par_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  if (DATA_W == 0 || DATA_W % 8 != 0) begin : g_width_check
    $error("ram_sp_param: DATA_W must be a non-zero multiple of 8");
  end

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [DATA_W-1:0] out_q;
  logic              rd_valid_q;
  logic              busy_q;
  logic              par_err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic do_clear;
  logic do_write;
  logic do_read;
  logic rd_par_err;

  // A reset edge drops any access presented on it.
  always_comb begin
    do_clear = !rst && (state_q == StClear);
    do_write = !rst && (state_q == StIdle) && en && we;
    do_read  = !rst && (state_q == StIdle) && en && !we;
  end

  always_ff @(posedge clk) begin
    if (do_clear) begin
      mem[clr_addr_q] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= in[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] rd_par_calc;

  // par_flip inverts the stored parity of the bytes being written, for error injection.
  always_ff @(posedge clk) begin
    if (do_clear) begin
      par_mem[clr_addr_q] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          par_mem[addr][i] <= (^in[8*i +: 8]) ^ par_flip;
        end
      end
    end
  end

  always_comb begin
    rd_par_calc = '0;
    for (int i = 0; i < BE_W; i++) begin
      rd_par_calc[i] = ^mem[addr][8*i +: 8];
    end
  end

  assign rd_par_err = |(rd_par_calc ^ par_mem[addr]);
`else
  logic unused_par_flip;
  assign unused_par_flip = par_flip;
  assign rd_par_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      out_q      <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
      par_err_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      unique case (state_q)
        StClear: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (&clr_addr_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          if (do_read) begin
            out_q      <= mem[addr];
            rd_valid_q <= 1'b1;
            par_err_q  <= rd_par_err;
          end
        end
        default: begin
          state_q <= StClear;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out      = out_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign par_err  = par_err_q;

endmodule

// File: doc/ram_sp_param.md
Name: ram_sp_param

Overview:
- Parametrised single-port synchronous RAM. Next generation of the team's 8-bit x 128 RAM.
- Generalised in data width and depth. Adds per-byte write enables, a read-valid strobe, and a self-clearing sweep after reset with a busy flag.
- Used as the general scratch or buffer memory behind bus-facing blocks.
- The defaults (DATA_W=8, ADDR_W=7) reproduce the legacy geometry.

Parameters:
- DATA_W, 8, data word width in bits. Must be a multiple of 8; elaboration fails otherwise.
- ADDR_W, 7, address width. Depth is DEPTH = 2**ADDR_W words.
- BE_W, DATA_W/8, number of byte enables. This is a derived localparam, not overridable.

Ports:
- clk      input   1        single clock; all logic updates on the rising edge
- rst      input   1        synchronous, active-high reset
- en       input   1        access enable
- we       input   1        write enable; 1 = write, 0 = read; only acts while en=1
- be       input   BE_W     byte write mask; bit i controls data bits [8i+7:8i]
- addr     input   ADDR_W   word address
- in       input   DATA_W   write data
- par_flip input   1        parity-error inject; only used when the optional feature is compiled in
- out      output  DATA_W   registered read data
- rd_valid output  1        one-cycle strobe qualifying out
- busy     output  1        clear sweep in progress; all accesses are ignored while high
- par_err  output  1        parity error strobe; tied 0 when the optional feature is compiled out

Behaviour:

Reset:
- Clock edge with rst=1: state<=CLEAR, clr_addr<=0, out<=0, rd_valid<=0, busy<=1, par_err<=0.
- While rst stays high, the block holds in CLEAR with clr_addr=0.

FSM states: CLEAR and IDLE.

CLEAR:
- Each edge with rst=0 writes 0 to mem[clr_addr] and increments clr_addr.
- The edge that writes address DEPTH-1 moves the state to IDLE and clears busy.
- busy therefore falls exactly DEPTH edges after the first edge with rst=0.
- During CLEAR, en/we/be/addr/in are ignored, out holds 0, rd_valid=0.

Reset mid-sweep or mid-operation:
- rst=1 at any time restarts the sweep at address 0.
- Any access presented on that edge is dropped.

IDLE, write (en=1, we=1):
- Bytes with be[i]=1 take in[8i+7:8i]; bytes with be[i]=0 keep their stored value.
- be=0 is a legal no-op write.
- out holds its previous value; rd_valid=0.

IDLE, read (en=1, we=0):
- out<=mem[addr] on the same edge (1-cycle latency).
- rd_valid=1 for that cycle only.
- Back-to-back reads give one result per cycle.

IDLE, idle (en=0):
- out holds its last value; rd_valid=0.

Write-then-read:
- A read at cycle N+1 of an address written at cycle N returns the new data. There is no bypass requirement beyond this.

Address width:
- Full 2**ADDR_W decode; no out-of-range case exists.

Optional Feature:

Macro RAM_PARITY_EN.

Defined:
- Each byte is stored with one even-parity bit.
- On a write, the parity of each enabled byte is recomputed. If par_flip=1, the stored parity of the written bytes is inverted.
- Masked bytes keep their old parity.
- The sweep stores 0 data with parity 0.
- On a read, parity is recomputed for every byte. par_err=1 alongside rd_valid if any byte mismatches; otherwise 0.
- par_err is never set outside a rd_valid cycle.

Undefined:
- No parity storage.
- par_flip is ignored and par_err is constant 0.
- Port list is identical in both builds.

Test Plan:
1. Reset and clear sweep:
   - Stimulus: DATA_W=8, ADDR_W=7; rst=1 for 2 cycles, then rst=0.
   - Required: busy stays 1 for exactly 128 edges after rst falls, then 0. Reads of addrs 0, 64 and 127 return 0 with rd_valid=1.
2. Legacy sequence:
   - Stimulus: write 55@2, 14@5, 42@19 with be=1; then read 5, then 2.
   - Required: out=14 then 55, one cycle after each read, rd_valid=1 each time. With en=0 at addr 19, out holds 55 and rd_valid=0.
3. Byte mask:
   - Stimulus: DATA_W=32; write 0xAABBCCDD@3 with be=4'b1111, then 0x11223344@3 with be=4'b0101.
   - Required: read of 3 returns 0xAA22CC44.
4. Access during busy:
   - Stimulus: write 0xFF@10 while busy=1; read 10 after busy falls.
   - Required: returns 0; no rd_valid during busy.
5. Reset mid-sweep:
   - Stimulus: after initial clear, write 0x5A@100; rst=1 for 1 cycle while reading 100.
   - Required: no rd_valid is produced for that read. busy stays high for 128 more edges, and addr 100 then reads 0.
6. Parity (RAM_PARITY_EN defined):
   - Stimulus: write 0x07@9 with par_flip=1; read 9.
   - Required: out=0x07, rd_valid=1, par_err=1. Rewriting with par_flip=0 and reading gives par_err=0.
   - With the macro undefined, par_err stays 0 throughout.
